// File: rtl/pipe_scoreboard_pkg.sv
// Shared types and constants for the register scoreboard.
// Optional bypass readiness is selected by PIPE_SCOREBOARD_BYPASS_EN.
package pipe_scoreboard_pkg;

  localparam int unsigned SB_NREG    = 32;
  localparam int unsigned SB_MAX_LAT = 4;
  localparam int unsigned SB_NSRC    = 2;

  localparam int unsigned SB_ADDR_W = $clog2(SB_NREG);
  localparam int unsigned SB_LAT_W  = $clog2(SB_MAX_LAT + 1);
  localparam int unsigned SB_SLOT_W = (SB_MAX_LAT > 1) ? $clog2(SB_MAX_LAT) : 1;

  typedef logic [SB_ADDR_W-1:0] RegAddr;
  typedef logic [SB_LAT_W-1:0]  SbLat;

  // Largest cnt value at which a consumer may still issue.
`ifdef PIPE_SCOREBOARD_BYPASS_EN
  localparam SbLat SB_RDY = SbLat'(1);
`else
  localparam SbLat SB_RDY = SbLat'(0);
`endif

  // Clamp a requested latency into the tracked range 1..SB_MAX_LAT.
  function automatic SbLat sb_norm_lat(input SbLat lat);
    if (lat == '0) begin
      return SbLat'(1);
    end
    if (lat > SbLat'(SB_MAX_LAT)) begin
      return SbLat'(SB_MAX_LAT);
    end
    return lat;
  endfunction

endpackage

// File: rtl/pipe_scoreboard_if.sv
// Decode-side issue bus of the scoreboard: issue request, sources, stall and forward hints.
interface pipe_scoreboard_if;
  import pipe_scoreboard_pkg::*;

  logic                       issue_valid;
  logic                       issue_kill;
  logic                       issue_we;
  RegAddr                     issue_dst;
  SbLat                       issue_lat;
  logic   [SB_NSRC-1:0]       src_valid;
  RegAddr [SB_NSRC-1:0]       src_addr;
  logic                       stall;
  logic   [SB_NSRC-1:0]       fwd_hit;

  modport master (
    output issue_valid, issue_kill, issue_we, issue_dst, issue_lat,
    output src_valid, src_addr,
    input  stall, fwd_hit
  );

  modport slave (
    input  issue_valid, issue_kill, issue_we, issue_dst, issue_lat,
    input  src_valid, src_addr,
    output stall, fwd_hit
  );

endinterface

// File: rtl/pipe_scoreboard_wb_ring.sv
// Write-back port occupancy ring: bit 0 is the write-back on the next edge.
// Queries look at the ring as it will stand after this edge's shift.
module sb_wb_ring
  import pipe_scoreboard_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic claim,
  input  SbLat lat,
  output logic slot_busy_c
);

  logic [SB_MAX_LAT-1:0] ring;
  logic [SB_MAX_LAT-1:0] shifted;
  logic [SB_MAX_LAT-1:0] ring_nxt;
  logic [SB_SLOT_W-1:0]  slot;

  assign shifted     = ring >> 1;
  assign slot        = SB_SLOT_W'(lat - SbLat'(1));
  assign slot_busy_c = shifted[slot];

  // Shift toward the port and mark the claimed slot.
  always_comb begin
    ring_nxt = shifted;
    for (int unsigned i = 0; i < SB_MAX_LAT; i++) begin
      if (claim && (slot == SB_SLOT_W'(i))) begin
        ring_nxt[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ring <= '0;
    end else begin
      ring <= ring_nxt;
    end
  end

endmodule

// File: rtl/pipe_scoreboard.sv
// Variable-latency register scoreboard: RAW/WAW/write-port hazards and forward hints.
// Define PIPE_SCOREBOARD_BYPASS_EN to let consumers issue one cycle before write-back.
module pipe_scoreboard
  import pipe_scoreboard_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  pipe_scoreboard_if.slave    sb,
  output logic [SB_NREG-1:0]  pending
);

  SbLat               cnt [SB_NREG];
  SbLat               lat_n;
  logic               raw_c;
  logic               waw_c;
  logic               wb_busy_c;
  logic               stall_c;
  logic               acc_c;
  logic [SB_NSRC-1:0] fwd_c;

  assign lat_n = sb_norm_lat(sb.issue_lat);

  sb_wb_ring u_wb_ring (
    .clk         (clk),
    .rst         (rst),
    .claim       (acc_c),
    .lat         (lat_n),
    .slot_busy_c (wb_busy_c)
  );

  // Hazards are judged against pre-issue state only.
  always_comb begin
    raw_c = 1'b0;
    for (int unsigned n = 0; n < SB_NSRC; n++) begin
      if (sb.src_valid[n] && (sb.src_addr[n] != '0) && (cnt[sb.src_addr[n]] > SB_RDY)) begin
        raw_c = 1'b1;
      end
    end
    waw_c   = sb.issue_we && (cnt[sb.issue_dst] > lat_n);
    stall_c = sb.issue_valid && !sb.issue_kill &&
              (raw_c || waw_c || (sb.issue_we && wb_busy_c));
    acc_c   = sb.issue_valid && !sb.issue_kill && !stall_c &&
              sb.issue_we && (sb.issue_dst != '0);
  end

  always_comb begin
    fwd_c = '0;
`ifdef PIPE_SCOREBOARD_BYPASS_EN
    for (int unsigned n = 0; n < SB_NSRC; n++) begin
      fwd_c[n] = sb.src_valid[n] && (sb.src_addr[n] != '0) &&
                 (cnt[sb.src_addr[n]] == SbLat'(1)) && !stall_c;
    end
`endif
  end

  assign sb.stall   = stall_c;
  assign sb.fwd_hit = fwd_c;

  always_comb begin
    pending = '0;
    for (int unsigned r = 0; r < SB_NREG; r++) begin
      pending[r] = (cnt[r] != '0);
    end
  end

  // A fresh write to a register replaces its countdown; r0 is never accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 0; r < SB_NREG; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < SB_NREG; r++) begin
        if (acc_c && (sb.issue_dst == RegAddr'(r))) begin
          cnt[r] <= lat_n;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - SbLat'(1);
        end
      end
    end
  end

  a_no_port_clash: assert property (@(posedge clk) disable iff (!rst) acc_c |-> !wb_busy_c);
  a_no_waw_reorder: assert property (@(posedge clk) disable iff (!rst) acc_c |-> (cnt[sb.issue_dst] <= lat_n));

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed bench for pipe_scoreboard; expectations follow PIPE_SCOREBOARD_BYPASS_EN.
module tb_pipe_scoreboard;
  import pipe_scoreboard_pkg::*;

`ifdef PIPE_SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic               clk;
  logic               rst;
  logic [SB_NREG-1:0] pending;
  int                 total;
  int                 bad;

  pipe_scoreboard_if sbif ();

  pipe_scoreboard dut (
    .clk     (clk),
    .rst     (rst),
    .sb      (sbif.slave),
    .pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sbif.issue_valid = 1'b0;
    sbif.issue_kill  = 1'b0;
    sbif.issue_we    = 1'b0;
    sbif.issue_dst   = '0;
    sbif.issue_lat   = '0;
    sbif.src_valid   = '0;
    sbif.src_addr    = '0;
  endtask

  task automatic issue(input int dst, input int lat);
    idle();
    sbif.issue_valid = 1'b1;
    sbif.issue_we    = 1'b1;
    sbif.issue_dst   = RegAddr'(dst);
    sbif.issue_lat   = SbLat'(lat);
  endtask

  task automatic read0(input int src);
    idle();
    sbif.issue_valid  = 1'b1;
    sbif.src_valid[0] = 1'b1;
    sbif.src_addr[0]  = RegAddr'(src);
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < int'(SB_MAX_LAT) + 1; i++) tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    idle();

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      sbif.issue_valid = 1'($urandom);
      sbif.issue_kill  = 1'($urandom);
      sbif.issue_we    = 1'($urandom);
      sbif.issue_dst   = RegAddr'($urandom);
      sbif.issue_lat   = SbLat'($urandom);
      sbif.src_valid   = SB_NSRC'($urandom);
      sbif.src_addr    = (SB_NSRC * SB_ADDR_W)'($urandom);
      #1;
      chk("rst_stall", 32'(sbif.stall), 32'd0);
      chk("rst_pending", 32'(pending), 32'd0);
      tick();
    end
    idle();
    rst = 1'b1;
    tick();
    tick();
    chk("post_rst_pending", 32'(pending), 32'd0);
    chk("post_rst_stall", 32'(sbif.stall), 32'd0);

    // Load-use on r5, latency 2
    issue(5, 2);
    #1 chk("lu_issue_stall", 32'(sbif.stall), 32'd0);
    tick();
    read0(5);
    #1;
    chk("lu_pend5", 32'(pending[5]), 32'd1);
    chk("lu_c1_stall", 32'(sbif.stall), 32'd1);
    chk("lu_c1_fwd", 32'(sbif.fwd_hit), 32'd0);
    tick();
    chk("lu_c2_stall", 32'(sbif.stall), BYP ? 32'd0 : 32'd1);
    chk("lu_c2_fwd", 32'(sbif.fwd_hit), BYP ? 32'd1 : 32'd0);
    tick();
    chk("lu_c3_stall", 32'(sbif.stall), 32'd0);
    chk("lu_c3_fwd", 32'(sbif.fwd_hit), 32'd0);
    chk("lu_c3_pend5", 32'(pending[5]), 32'd0);
    drain();

    // WAW on r8: lat 4 then lat 1
    issue(8, 4);
    tick();
    issue(8, 1);
    #1 chk("waw_c1_stall", 32'(sbif.stall), 32'd1);
    tick();
    chk("waw_c2_stall", 32'(sbif.stall), 32'd1);
    tick();
    chk("waw_c3_stall", 32'(sbif.stall), 32'd1);
    tick();
    chk("waw_c4_stall", 32'(sbif.stall), 32'd0);
    tick();
    idle();
    #1 chk("waw_pend8_hold", 32'(pending[8]), 32'd1);
    tick();
    chk("waw_pend8_clear", 32'(pending[8]), 32'd0);
    drain();

    // Write-back port conflict: r2 lat 3 then r3 lat 2
    issue(2, 3);
    tick();
    issue(3, 2);
    #1 chk("port_c1_stall", 32'(sbif.stall), 32'd1);
    tick();
    chk("port_c2_stall", 32'(sbif.stall), 32'd0);
    tick();
    idle();
    #1 chk("port_pend_both", 32'(pending[3:2]), 32'd3);
    tick();
    chk("port_pend_r3", 32'(pending[3:2]), 32'd2);
    tick();
    chk("port_pend_none", 32'(pending[3:2]), 32'd0);
    drain();

    // Kill and register zero
    issue(9, 4);
    sbif.issue_kill = 1'b1;
    #1 chk("kill_stall", 32'(sbif.stall), 32'd0);
    tick();
    chk("kill_pend9", 32'(pending[9]), 32'd0);
    issue(0, 4);
    #1 chk("r0_stall", 32'(sbif.stall), 32'd0);
    tick();
    chk("r0_pending", 32'(pending), 32'd0);
    idle();
    sbif.issue_valid = 1'b1;
    sbif.src_valid   = '1;
    #1;
    chk("r0_read_stall", 32'(sbif.stall), 32'd0);
    chk("r0_read_fwd", 32'(sbif.fwd_hit), 32'd0);
    issue(6, 3);
    tick();
    read0(6);
    sbif.issue_kill = 1'b1;
    #1 chk("kill_masks_raw", 32'(sbif.stall), 32'd0);
    sbif.issue_kill = 1'b0;
    #1 chk("raw_unkilled", 32'(sbif.stall), 32'd1);
    drain();

    // Same register as source and destination
    issue(12, 2);
    tick();
    issue(12, 2);
    sbif.src_valid[1] = 1'b1;
    sbif.src_addr[1]  = RegAddr'(12);
    #1 chk("self_raw_stall", 32'(sbif.stall), 32'd1);
    drain();

    // Latency saturation
    issue(10, 0);
    tick();
    idle();
    #1 chk("lat0_pend", 32'(pending[10]), 32'd1);
    tick();
    chk("lat0_clear", 32'(pending[10]), 32'd0);
    issue(11, 7);
    tick();
    idle();
    for (int k = 0; k < 4; k++) begin
      chk("lat7_pend", 32'(pending[11]), 32'd1);
      tick();
    end
    chk("lat7_clear", 32'(pending[11]), 32'd0);
    drain();

    // Reset mid-operation discards in-flight writes
    issue(13, 4);
    tick();
    idle();
    #1 chk("mid_pend13", 32'(pending[13]), 32'd1);
    rst = 1'b0;
    #1 chk("mid_rst_pending", 32'(pending), 32'd0);
    #1 rst = 1'b1;
    tick();
    chk("mid_after_pending", 32'(pending), 32'd0);
    issue(13, 1);
    #1 chk("mid_after_stall", 32'(sbif.stall), 32'd0);
    tick();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
